// File: rtl/adder_operand_loader_if.sv
// Handshake bundle between the beat stream, the operand loader and the adder.
// master: the environment (beat source + adder side); slave: the loader.
interface adder_operand_loader_if #(
    parameter int DATA_W = 100,
    parameter int BEAT_W = 10
);
    logic              in_flush;
    logic              in_valid;
    logic              in_ready;
    logic [BEAT_W-1:0] in_data;
    logic              in_cin;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              Cin;

    modport master (
        output in_flush, in_valid, in_data, in_cin, out_ready,
        input  in_ready, out_valid, A, B, Cin
    );

    modport slave (
        input  in_flush, in_valid, in_data, in_cin, out_ready,
        output in_ready, out_valid, A, B, Cin
    );
endinterface

// File: rtl/adder_operand_loader.sv
// Beat-serial operand loader: assembles A, B and Cin for the wide adder from a
// narrow valid/ready stream and holds them stable until the adder consumes them.
module adder_operand_loader #(
    parameter int DATA_W = 100,
    parameter int BEAT_W = 10,
    localparam int BEATS = DATA_W / BEAT_W
) (
    input logic                   clk,
    input logic                   rst_n,
    adder_operand_loader_if.slave bus
);
    if ((DATA_W != BEATS * BEAT_W) || (BEATS < 1) || (BEATS > 16)) begin : g_width_check
        $error("DATA_W must be an exact multiple of BEAT_W with 1..16 beats");
    end

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        HOLD
    } state_t;

    localparam logic [3:0] LAST = 4'(BEATS - 1);

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic              in_ready;
    logic              accept;
    logic              last_beat;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              cin_q;
    logic              out_valid_q;

    assign accept    = bus.in_valid && in_ready;
    assign last_beat = (cnt == LAST);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.Cin       = cin_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.in_flush) begin
            state_next = LOAD_A;
        end else begin
            unique case (state)
                LOAD_A: if (accept && last_beat) state_next = LOAD_B;
                LOAD_B: if (accept && last_beat) state_next = HOLD;
                HOLD:   if (out_valid_q && bus.out_ready) state_next = LOAD_A;
                default: state_next = LOAD_A;
            endcase
        end
    end

    // in_ready decodes state alone, so it never depends on in_valid or out_ready
    always_comb begin
        in_ready = (state != HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (bus.in_flush) begin
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            cnt <= last_beat ? '0 : cnt + 4'd1;
            if (state == LOAD_A) begin
                a_q[cnt*BEAT_W +: BEAT_W] <= bus.in_data;
            end else begin
                b_q[cnt*BEAT_W +: BEAT_W] <= bus.in_data;
            end
            if ((state == LOAD_B) && last_beat) begin
                cin_q       <= bus.in_cin;
                out_valid_q <= 1'b1;
            end
        end else if ((state == HOLD) && out_valid_q && bus.out_ready) begin
            // operands are deliberately retained after the handshake
            out_valid_q <= 1'b0;
        end
    end
endmodule
